// File: rtl/faux_hd_data_io_pkg.sv
// -----------------------------------------------------------------------------
// faux_hd_data_io_pkg
//   Shared widths and helpers for the faux hard-drive data endpoint.
//   ERR_CNT_W  : width of the saturating mismatch counter
//   WORD_CNT_W : width of the wrapping word counters on both paths
//   sat_inc_err: increment that sticks at all-ones instead of wrapping
// -----------------------------------------------------------------------------
package faux_hd_data_io_pkg;

  localparam int unsigned ERR_CNT_W  = 16;
  localparam int unsigned WORD_CNT_W = 24;

  function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
    if (&v) return v;
    return v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/faux_hd_pattern_counter.sv
// -----------------------------------------------------------------------------
// faux_hd_pattern_counter
//   Registered incrementing-pattern source. Holds START_VALUE while cleared,
//   steps by INCREMENT (mod 2**DATA_WIDTH) on each advance.
//   clk     : clock
//   rst     : synchronous active-high reset (to START_VALUE)
//   clear   : synchronous clear (to START_VALUE), same effect as rst
//   advance : step the pattern this cycle
//   value   : current pattern word (registered)
// -----------------------------------------------------------------------------
module faux_hd_pattern_counter
  import faux_hd_data_io_pkg::*;
#(
  parameter int unsigned               DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0]     START_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0]     INCREMENT   = DATA_WIDTH'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] value
);

  logic [DATA_WIDTH-1:0] value_q;
  logic [DATA_WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clear)        value_d = START_VALUE;
    else if (advance) value_d = value_q + INCREMENT;
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= START_VALUE;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/faux_hd_data_io.sv
// -----------------------------------------------------------------------------
// faux_hd_data_io
//   Data endpoint behind the faux SATA drive model. The checker path verifies
//   that words received from the host follow an incrementing pattern; the
//   generator path supplies an incrementing pattern for the drive to send.
//
//   Strobe semantics (both paths): a word is transferred in exactly the cycle
//   its strobe is high while the path's enable is high. There is no
//   back-pressure; a strobe every cycle is legal. On the generator side the
//   word is presented before the strobe (show-ahead) and advances the cycle
//   after it.
//
//   Checker ports : rd_enable, hd_read_from_host, hd_data_from_host,
//                   rd_error, rd_error_count, rd_word_count, rd_first_bad_data
//   Generator ports: wr_enable, hd_write_to_host, hd_data_to_host,
//                   wr_word_count
// -----------------------------------------------------------------------------
module faux_hd_data_io
  import faux_hd_data_io_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] START_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] INCREMENT   = DATA_WIDTH'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  // checker path
  input  logic                  rd_enable,
  input  logic                  hd_read_from_host,
  input  logic [DATA_WIDTH-1:0] hd_data_from_host,
  output logic                  rd_error,
  output logic [ERR_CNT_W-1:0]  rd_error_count,
  output logic [WORD_CNT_W-1:0] rd_word_count,
  output logic [DATA_WIDTH-1:0] rd_first_bad_data,
  // generator path
  input  logic                  wr_enable,
  input  logic                  hd_write_to_host,
  output logic [DATA_WIDTH-1:0] hd_data_to_host,
  output logic [WORD_CNT_W-1:0] wr_word_count
);

  // ---------------------------------------------------------------- checker
  logic                  rd_xfer;
  logic                  rd_mismatch;
  logic [DATA_WIDTH-1:0] rd_expected;

  assign rd_xfer     = rd_enable & hd_read_from_host;
  assign rd_mismatch = rd_xfer & (hd_data_from_host != rd_expected);

  // Expected value steps from itself, never from received data, so one bad
  // word does not shift the rest of the stream out of alignment.
  faux_hd_pattern_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .START_VALUE(START_VALUE),
    .INCREMENT  (INCREMENT)
  ) u_rd_expected (
    .clk    (clk),
    .rst    (rst),
    .clear  (~rd_enable),
    .advance(rd_xfer),
    .value  (rd_expected)
  );

  logic                  rd_error_q,     rd_error_d;
  logic [ERR_CNT_W-1:0]  rd_err_cnt_q,   rd_err_cnt_d;
  logic [WORD_CNT_W-1:0] rd_word_cnt_q,  rd_word_cnt_d;
  logic [DATA_WIDTH-1:0] rd_first_bad_q, rd_first_bad_d;

  always_comb begin
    rd_error_d     = rd_error_q;
    rd_err_cnt_d   = rd_err_cnt_q;
    rd_word_cnt_d  = rd_word_cnt_q;
    rd_first_bad_d = rd_first_bad_q;
    if (!rd_enable) begin
      rd_error_d     = 1'b0;
      rd_err_cnt_d   = '0;
      rd_word_cnt_d  = '0;
      rd_first_bad_d = '0;
    end else if (rd_xfer) begin
      rd_word_cnt_d = rd_word_cnt_q + WORD_CNT_W'(1);
      if (rd_mismatch) begin
        rd_error_d   = 1'b1;
        rd_err_cnt_d = sat_inc_err(rd_err_cnt_q);
        // Only the first bad word since arming is kept.
        if (!rd_error_q) rd_first_bad_d = hd_data_from_host;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_error_q     <= 1'b0;
      rd_err_cnt_q   <= '0;
      rd_word_cnt_q  <= '0;
      rd_first_bad_q <= '0;
    end else begin
      rd_error_q     <= rd_error_d;
      rd_err_cnt_q   <= rd_err_cnt_d;
      rd_word_cnt_q  <= rd_word_cnt_d;
      rd_first_bad_q <= rd_first_bad_d;
    end
  end

  assign rd_error          = rd_error_q;
  assign rd_error_count    = rd_err_cnt_q;
  assign rd_word_count     = rd_word_cnt_q;
  assign rd_first_bad_data = rd_first_bad_q;

  // -------------------------------------------------------------- generator
  logic                  wr_xfer;
  logic [WORD_CNT_W-1:0] wr_word_cnt_q, wr_word_cnt_d;

  assign wr_xfer = wr_enable & hd_write_to_host;

  faux_hd_pattern_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .START_VALUE(START_VALUE),
    .INCREMENT  (INCREMENT)
  ) u_wr_pattern (
    .clk    (clk),
    .rst    (rst),
    .clear  (~wr_enable),
    .advance(wr_xfer),
    .value  (hd_data_to_host)
  );

  always_comb begin
    wr_word_cnt_d = wr_word_cnt_q;
    if (!wr_enable)   wr_word_cnt_d = '0;
    else if (wr_xfer) wr_word_cnt_d = wr_word_cnt_q + WORD_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) wr_word_cnt_q <= '0;
    else     wr_word_cnt_q <= wr_word_cnt_d;
  end

  assign wr_word_count = wr_word_cnt_q;

endmodule

// File: tb/tb_faux_hd_data_io.sv
// -----------------------------------------------------------------------------
// tb_faux_hd_data_io
//   Directed bench for faux_hd_data_io: a 32-bit instance for the main checker,
//   generator and reset scenarios, and an 8-bit instance for pattern wrap.
// -----------------------------------------------------------------------------
module tb_faux_hd_data_io;

  // ------------------------------------------------------- clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ----------------------------------------------------------- 32-bit DUT
  logic        rd_enable = 1'b0, hd_read_from_host = 1'b0;
  logic [31:0] hd_data_from_host = '0;
  logic        rd_error;
  logic [15:0] rd_error_count;
  logic [23:0] rd_word_count;
  logic [31:0] rd_first_bad_data;
  logic        wr_enable = 1'b0, hd_write_to_host = 1'b0;
  logic [31:0] hd_data_to_host;
  logic [23:0] wr_word_count;

  faux_hd_data_io #(.DATA_WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .rd_enable        (rd_enable),
    .hd_read_from_host(hd_read_from_host),
    .hd_data_from_host(hd_data_from_host),
    .rd_error         (rd_error),
    .rd_error_count   (rd_error_count),
    .rd_word_count    (rd_word_count),
    .rd_first_bad_data(rd_first_bad_data),
    .wr_enable        (wr_enable),
    .hd_write_to_host (hd_write_to_host),
    .hd_data_to_host  (hd_data_to_host),
    .wr_word_count    (wr_word_count)
  );

  // ------------------------------------------------------------ 8-bit DUT
  logic        rd_enable8 = 1'b0, hd_read_from_host8 = 1'b0;
  logic [7:0]  hd_data_from_host8 = '0;
  logic        rd_error8;
  logic [15:0] rd_error_count8;
  logic [23:0] rd_word_count8;
  logic [7:0]  rd_first_bad_data8;
  logic        wr_enable8 = 1'b0, hd_write_to_host8 = 1'b0;
  logic [7:0]  hd_data_to_host8;
  logic [23:0] wr_word_count8;

  faux_hd_data_io #(.DATA_WIDTH(8)) dut8 (
    .clk              (clk),
    .rst              (rst),
    .rd_enable        (rd_enable8),
    .hd_read_from_host(hd_read_from_host8),
    .hd_data_from_host(hd_data_from_host8),
    .rd_error         (rd_error8),
    .rd_error_count   (rd_error_count8),
    .rd_word_count    (rd_word_count8),
    .rd_first_bad_data(rd_first_bad_data8),
    .wr_enable        (wr_enable8),
    .hd_write_to_host (hd_write_to_host8),
    .hd_data_to_host  (hd_data_to_host8),
    .wr_word_count    (wr_word_count8)
  );

  // ------------------------------------------------------------ scoreboard
  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------- driver tasks
  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_word(input logic [31:0] d);
    hd_data_from_host = d;
    hd_read_from_host = 1'b1;
    tick();
    hd_read_from_host = 1'b0;
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    // Reset
    rst = 1'b1;
    tick(); tick();
    check_val("rst_rd_error",   32'(rd_error), 32'd0);
    check_val("rst_err_cnt",    32'(rd_error_count), 32'd0);
    check_val("rst_rd_words",   32'(rd_word_count), 32'd0);
    check_val("rst_first_bad",  rd_first_bad_data, 32'd0);
    check_val("rst_data_out",   hd_data_to_host, 32'd0);
    check_val("rst_wr_words",   32'(wr_word_count), 32'd0);
    rst = 1'b0;
    tick();

    // 1. Checker pass: 0..511
    rd_enable = 1'b1;
    hd_read_from_host = 1'b1;
    for (int i = 0; i < 512; i++) begin
      hd_data_from_host = 32'(i);
      tick();
    end
    hd_read_from_host = 1'b0;
    check_val("t1_rd_error",  32'(rd_error), 32'd0);
    check_val("t1_rd_words",  32'(rd_word_count), 32'd512);
    check_val("t1_err_cnt",   32'(rd_error_count), 32'd0);

    // 2. Checker fail: 0,1,7,3 then 4,5 pass, then a second bad word
    rd_enable = 1'b0; tick();
    rd_enable = 1'b1;
    rd_word(32'd0);
    rd_word(32'd1);
    check_val("t2_clean_before_bad", 32'(rd_error), 32'd0);
    rd_word(32'd7);
    check_val("t2_error_next_cycle", 32'(rd_error), 32'd1);
    rd_word(32'd3);
    check_val("t2_rd_error",   32'(rd_error), 32'd1);
    check_val("t2_err_cnt",    32'(rd_error_count), 32'd1);
    check_val("t2_first_bad",  rd_first_bad_data, 32'd7);
    check_val("t2_rd_words",   32'(rd_word_count), 32'd4);
    rd_word(32'd4);
    rd_word(32'd5);
    check_val("t2_resync_err_cnt", 32'(rd_error_count), 32'd1);
    check_val("t2_resync_words",   32'(rd_word_count), 32'd6);
    rd_word(32'd99);
    check_val("t2_second_bad_cnt",  32'(rd_error_count), 32'd2);
    check_val("t2_first_bad_kept",  rd_first_bad_data, 32'd7);

    // 3. Re-arm: one cycle low (strobe ignored), then 0,1 with strobe on the
    //    first enabled cycle
    rd_enable = 1'b0;
    hd_data_from_host = 32'd55;
    hd_read_from_host = 1'b1;
    tick();
    hd_read_from_host = 1'b0;
    check_val("t3_cleared_error", 32'(rd_error), 32'd0);
    check_val("t3_cleared_errs",  32'(rd_error_count), 32'd0);
    check_val("t3_cleared_words", 32'(rd_word_count), 32'd0);
    check_val("t3_cleared_bad",   rd_first_bad_data, 32'd0);
    rd_enable = 1'b1;
    rd_word(32'd0);
    rd_word(32'd1);
    check_val("t3_rd_error", 32'(rd_error), 32'd0);
    check_val("t3_rd_words", 32'(rd_word_count), 32'd2);
    rd_enable = 1'b0;

    // 4. Generator: show-ahead, 4 back-to-back strobes, gap, one more
    wr_enable = 1'b1;
    tick();
    check_val("t4_showahead", hd_data_to_host, 32'd0);
    hd_write_to_host = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t4_strobe_data%0d", i), hd_data_to_host, 32'(i));
      tick();
    end
    hd_write_to_host = 1'b0;
    check_val("t4_data_after", hd_data_to_host, 32'd4);
    check_val("t4_wr_words",   32'(wr_word_count), 32'd4);
    tick(); tick(); tick();
    check_val("t4_gap_hold",   hd_data_to_host, 32'd4);
    hd_write_to_host = 1'b1; tick(); hd_write_to_host = 1'b0;
    check_val("t4_data_5",     hd_data_to_host, 32'd5);
    check_val("t4_wr_words_5", 32'(wr_word_count), 32'd5);
    wr_enable = 1'b0;
    tick();
    check_val("t4_disable_data",  hd_data_to_host, 32'd0);
    check_val("t4_disable_words", 32'(wr_word_count), 32'd0);

    // 5. Wrap on the 8-bit instance: generator looped into checker
    wr_enable8 = 1'b1;
    rd_enable8 = 1'b1;
    tick();
    hd_write_to_host8  = 1'b1;
    hd_read_from_host8 = 1'b1;
    for (int i = 0; i < 257; i++) begin
      hd_data_from_host8 = hd_data_to_host8;
      if (i >= 254) check_val($sformatf("t5_gen_word%0d", i), 32'(hd_data_to_host8), 32'(i % 256));
      tick();
    end
    hd_write_to_host8  = 1'b0;
    hd_read_from_host8 = 1'b0;
    check_val("t5_data_after_wrap", 32'(hd_data_to_host8), 32'd1);
    check_val("t5_wr_words",        32'(wr_word_count8), 32'd257);
    check_val("t5_rd_words",        32'(rd_word_count8), 32'd257);
    check_val("t5_rd_error",        32'(rd_error8), 32'd0);

    // 6. Reset mid-transfer on both paths
    rd_enable = 1'b1;
    wr_enable = 1'b1;
    hd_read_from_host = 1'b1;
    hd_write_to_host  = 1'b1;
    hd_data_from_host = 32'd0; tick();
    hd_data_from_host = 32'd9; tick();
    hd_data_from_host = 32'd2; tick();
    check_val("t6_pre_error", 32'(rd_error), 32'd1);
    check_val("t6_pre_data",  hd_data_to_host, 32'd3);
    rst = 1'b1;
    tick();
    check_val("t6_rd_error",   32'(rd_error), 32'd0);
    check_val("t6_err_cnt",    32'(rd_error_count), 32'd0);
    check_val("t6_rd_words",   32'(rd_word_count), 32'd0);
    check_val("t6_first_bad",  rd_first_bad_data, 32'd0);
    check_val("t6_data_out",   hd_data_to_host, 32'd0);
    check_val("t6_wr_words",   32'(wr_word_count), 32'd0);
    rst = 1'b0;
    hd_read_from_host = 1'b0;
    hd_write_to_host  = 1'b0;
    tick();

    // --------------------------------------------------------- report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
